// File: rtl/op_sched_pkg.sv
// Shared types and defaults for the round-robin operation scheduler.
// States is the engine sequencing state; code 3 is never entered legally.
package op_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GO   = 2'd1,
        DONE = 2'd2
    } States;

    localparam int NREQ_DEFAULT = 4;
    localparam int LW_DEFAULT   = 8;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set req bit strictly after ptr, wrapping.
// Purely combinational so it can be shared by other arbiters.
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic                    valid,
    output logic [$clog2(NREQ)-1:0] winner,
    output logic [NREQ-1:0]         onehot
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] idx_s;

    // Scan upward from ptr+1; the first hit wins, later hits are ignored.
    always_comb begin
        valid  = 1'b0;
        winner = {IW{1'b0}};
        onehot = {NREQ{1'b0}};
        idx_s  = {IW{1'b0}};
        for (int i = 1; i <= NREQ; i++) begin
            idx_s = IW'((int'(ptr) + i) % NREQ);
            if (!valid && req[idx_s]) begin
                valid  = 1'b1;
                winner = idx_s;
            end else begin
                valid  = valid;
            end
        end
        if (valid) begin
            onehot = NREQ'(1) << winner;
        end else begin
            onehot = {NREQ{1'b0}};
        end
    end

endmodule

// File: rtl/op_rr_sched.sv
// Round-robin owner of a shared IDLE -> GO -> DONE engine.
// Grant and owner are registered; ctl/done/busy decode the state register only.
module op_rr_sched
    import op_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int LW   = LW_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [LW-1:0]           cfg_go_len,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    ctl,
    output logic                    done,
    output logic                    busy,
    output logic [1:0]              state
);

    localparam int IW = $clog2(NREQ);

    States          state_r, state_n;
    logic [LW-1:0]  cnt_r, cnt_n;
    logic [IW-1:0]  ptr_r, ptr_n;
    logic [NREQ-1:0] gnt_r, gnt_n;
    logic [IW-1:0]  owner_r, owner_n;

    logic           pick_valid_s;
    logic [IW-1:0]  pick_idx_s;
    logic [NREQ-1:0] pick_oh_s;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (req),
        .ptr    (ptr_r),
        .valid  (pick_valid_s),
        .winner (pick_idx_s),
        .onehot (pick_oh_s)
    );

    // State, counter, pointer and grant registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {LW{1'b0}};
            ptr_r   <= IW'(NREQ - 1);
            gnt_r   <= {NREQ{1'b0}};
            owner_r <= {IW{1'b0}};
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            ptr_r   <= ptr_n;
            gnt_r   <= gnt_n;
            owner_r <= owner_n;
        end
    end

    // Next-state logic; a zero length still yields one GO cycle.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        ptr_n   = ptr_r;
        gnt_n   = gnt_r;
        owner_n = owner_r;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    gnt_n   = pick_oh_s;
                    owner_n = pick_idx_s;
                    state_n = GO;
                    if (cfg_go_len == {LW{1'b0}}) begin
                        cnt_n = {LW{1'b0}};
                    end else begin
                        cnt_n = cfg_go_len - LW'(1);
                    end
                end else begin
                    gnt_n = {NREQ{1'b0}};
                end
            end
            GO: begin
                if (cnt_r == {LW{1'b0}}) begin
                    state_n = DONE;
                end else begin
                    cnt_n = cnt_r - LW'(1);
                end
            end
            DONE: begin
                ptr_n   = owner_r;
                gnt_n   = {NREQ{1'b0}};
                state_n = IDLE;
            end
            default: begin
                gnt_n   = {NREQ{1'b0}};
                state_n = IDLE;
            end
        endcase
    end

    // Engine strobes come from the state register alone.
    always_comb begin
        ctl  = 1'b0;
        done = 1'b0;
        busy = 1'b0;
        case (state_r)
            GO: begin
                ctl  = 1'b1;
                busy = 1'b1;
            end
            DONE: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: begin
                ctl  = 1'b0;
                done = 1'b0;
                busy = 1'b0;
            end
        endcase
    end

    assign gnt   = gnt_r;
    assign owner = owner_r;
    assign state = state_r;

endmodule

// File: tb/tb_op_rr_sched.sv
// Directed bench for op_rr_sched: expected owners are queued at grant time
// and popped on every done pulse; cycle-level checks cover timing and reset.
module tb_op_rr_sched;
    import op_sched_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [7:0] cfg_go_len;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       ctl;
    logic       done;
    logic       busy;
    logic [1:0] state;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int exp_q[$];

    op_rr_sched #(.NREQ(4), .LW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .cfg_go_len (cfg_go_len),
        .gnt        (gnt),
        .owner      (owner),
        .ctl        (ctl),
        .done       (done),
        .busy       (busy),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every done pulse must match the oldest queued owner.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() > 0) begin
                int e;
                logic [3:0] oh;
                e  = exp_q.pop_front();
                oh = 4'b0001 << e;
                chk("sb_done_gnt", 32'(gnt), 32'(oh));
                chk("sb_done_owner", 32'(owner), 32'(e));
            end else begin
                chk("sb_unexpected_done", 32'(done), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int n;
        logic [3:0] oh;

        rst = 1'b1; req = 4'b0000; cfg_go_len = 8'd0;
        step();
        step();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_ctl", 32'(ctl), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        rst = 1'b0;

        // Single requester, length 3.
        req = 4'b0001; cfg_go_len = 8'd3; exp_q.push_back(0);
        step();
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_ctl_c1", 32'(ctl), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_state_go", 32'(state), 32'd1);
        step(); chk("t1_ctl_c2", 32'(ctl), 32'd1);
        step(); chk("t1_ctl_c3", 32'(ctl), 32'd1);
        step();
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_ctl_off", 32'(ctl), 32'd0);
        chk("t1_gnt_done", 32'(gnt), 32'h1);
        chk("t1_state_done", 32'(state), 32'd2);
        req = 4'b0000;
        step();
        chk("t1_idle_state", 32'(state), 32'd0);
        chk("t1_idle_gnt", 32'(gnt), 32'd0);
        chk("t1_idle_done", 32'(done), 32'd0);

        // All four held, length 1: order 0,1,2,3,0 after a fresh reset.
        rst = 1'b1;
        step();
        rst = 1'b0; req = 4'b1111; cfg_go_len = 8'd1;
        for (int k = 0; k < 5; k++) exp_q.push_back(k % 4);
        d0 = done_cnt;
        for (int k = 0; k < 5; k++) begin
            step();
            oh = 4'b0001 << (k % 4);
            chk("rr_gnt", 32'(gnt), 32'(oh));
            chk("rr_ctl", 32'(ctl), 32'd1);
            step();
            chk("rr_done", 32'(done), 32'd1);
            step();
            chk("rr_idle", 32'(state), 32'd0);
            chk("rr_idle_gnt", 32'(gnt), 32'd0);
            if (k == 4) req = 4'b0000;
        end
        chk("rr_done_count", 32'(done_cnt - d0), 32'd5);

        // Zero length behaves as one GO cycle.
        req = 4'b0010; cfg_go_len = 8'd0; exp_q.push_back(1);
        step();
        chk("len0_ctl", 32'(ctl), 32'd1);
        chk("len0_owner", 32'(owner), 32'd1);
        step();
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_ctl_off", 32'(ctl), 32'd0);
        req = 4'b0000;
        step();

        // Length change during GO is ignored.
        req = 4'b0001; cfg_go_len = 8'd2; exp_q.push_back(0);
        step();
        chk("cfgchg_gnt", 32'(gnt), 32'h1);
        cfg_go_len = 8'd9;
        step();
        chk("cfgchg_ctl2", 32'(ctl), 32'd1);
        step();
        chk("cfgchg_done", 32'(done), 32'd1);
        req = 4'b0000;
        step();

        // Maximum length 255 with no counter overflow.
        req = 4'b0001; cfg_go_len = 8'd255; exp_q.push_back(0);
        n = 0;
        step();
        while (ctl === 1'b1 && n < 300) begin
            n++;
            step();
        end
        chk("maxlen_ctl_cycles", 32'(n), 32'd255);
        chk("maxlen_done", 32'(done), 32'd1);
        req = 4'b0000;
        step();

        // Owner 2 drops its request mid-GO; next grant goes to 3.
        req = 4'b1101; cfg_go_len = 8'd3; exp_q.push_back(2);
        step();
        chk("drop_gnt", 32'(gnt), 32'h4);
        chk("drop_owner", 32'(owner), 32'd2);
        req = 4'b1001;
        step(); step(); step();
        chk("drop_done", 32'(done), 32'd1);
        chk("drop_done_gnt", 32'(gnt), 32'h4);
        exp_q.push_back(3);
        step();
        chk("drop_idle", 32'(state), 32'd0);
        step();
        chk("drop_next_gnt", 32'(gnt), 32'h8);
        chk("drop_next_owner", 32'(owner), 32'd3);
        step(); step(); step();
        req = 4'b0000;
        step();

        // Move the pointer to 1 so req[3] would win without a reset.
        req = 4'b0010; cfg_go_len = 8'd1; exp_q.push_back(1);
        step();
        chk("ptr1_gnt", 32'(gnt), 32'h2);
        step();
        req = 4'b0000;
        step();

        // Reset in the middle of GO aborts with no done pulse.
        req = 4'b1001; cfg_go_len = 8'd10;
        step();
        chk("abort_gnt", 32'(gnt), 32'h8);
        step(); step(); step(); step();
        chk("abort_ctl_before", 32'(ctl), 32'd1);
        rst = 1'b1;
        step();
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_gnt_off", 32'(gnt), 32'd0);
        chk("abort_ctl_off", 32'(ctl), 32'd0);
        chk("abort_done_off", 32'(done), 32'd0);
        chk("abort_busy_off", 32'(busy), 32'd0);
        rst = 1'b0; cfg_go_len = 8'd1; exp_q.push_back(0);
        step();
        chk("post_rst_gnt", 32'(gnt), 32'h1);
        chk("post_rst_owner", 32'(owner), 32'd0);
        step();
        req = 4'b0000;
        step();

        // Illegal state code 3 decodes to idle outputs and recovers.
        force dut.state_r = States'(2'd3);
        #1;
        chk("ill_state", 32'(state), 32'd3);
        chk("ill_ctl", 32'(ctl), 32'd0);
        chk("ill_done", 32'(done), 32'd0);
        chk("ill_busy", 32'(busy), 32'd0);
        release dut.state_r;
        step();
        chk("ill_recover", 32'(state), 32'd0);
        chk("ill_recover_gnt", 32'(gnt), 32'd0);

        chk("sb_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
